// File: rtl/iot_data_filter.sv
// Streaming IoT filter: assembles 16 serial bytes into 128-bit data and applies max/min/avg/extract/exclude/peak functions.
// Latency: result registered, valid pulses the cycle after the edge that samples the completing byte.
// Backpressure: none; busy is tied low and a byte is accepted on every in_en cycle.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   in_en    iot_in carries a valid byte this cycle
//   iot_in   data byte, most significant byte of each datum first
//   fn_sel   function select: 1 max, 2 min, 3 avg, 4 extract, 5 exclude, 6 peak-max, 7 peak-min
//   busy     always 0
//   valid    one-cycle result strobe
//   iot_out  result datum, held between strobes
module iot_data_filter #(
    parameter logic [127:0] F4_LOW  = 128'h6FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
    parameter logic [127:0] F4_HIGH = 128'hAFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
    parameter logic [127:0] F5_LOW  = 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
    parameter logic [127:0] F5_HIGH = 128'hBFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_en,
    input  logic [7:0]   iot_in,
    input  logic [2:0]   fn_sel,
    output logic         busy,
    output logic         valid,
    output logic [127:0] iot_out
);

    // Only the 15 most recent bytes are ever needed: the 16th byte is
    // taken straight from iot_in when the datum completes.
    logic [119:0] shift_q, shift_d;
    logic [3:0]   byte_cnt_q, byte_cnt_d;
    logic [2:0]   dat_cnt_q, dat_cnt_d;
    logic [130:0] acc_q, acc_d;
    logic [127:0] peak_q, peak_d;
    logic         first_q, first_d;
    logic         valid_q, valid_d;
    logic [127:0] out_q, out_d;

    logic [127:0] datum;
    logic [130:0] d_ext;
    logic [130:0] run_max;
    logic [130:0] run_min;
    logic [130:0] run_sum;
    logic         last_byte;
    logic         last_dat;

    always_comb begin
        datum     = {shift_q, iot_in};
        d_ext     = {3'b000, datum};
        last_byte = in_en && (byte_cnt_q == 4'hF);
        last_dat  = (dat_cnt_q == 3'd7);

        // The first datum of a round seeds the running value, so the
        // accumulator contents left from the previous round never matter.
        run_max = ((dat_cnt_q == 3'd0) || (d_ext > acc_q)) ? d_ext : acc_q;
        run_min = ((dat_cnt_q == 3'd0) || (d_ext < acc_q)) ? d_ext : acc_q;
        run_sum = (dat_cnt_q == 3'd0) ? d_ext : (acc_q + d_ext);

        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        dat_cnt_d  = dat_cnt_q;
        acc_d      = acc_q;
        peak_d     = peak_q;
        first_d    = first_q;
        valid_d    = 1'b0;
        out_d      = out_q;

        if (in_en) begin
            shift_d    = datum[119:0];
            byte_cnt_d = byte_cnt_q + 4'd1;
        end

        if (last_byte) begin
            dat_cnt_d = dat_cnt_q + 3'd1;
            case (fn_sel)
                3'd1: begin
                    acc_d = last_dat ? '0 : run_max;
                    if (last_dat) begin
                        valid_d = 1'b1;
                        out_d   = run_max[127:0];
                    end
                end
                3'd2: begin
                    acc_d = last_dat ? '0 : run_min;
                    if (last_dat) begin
                        valid_d = 1'b1;
                        out_d   = run_min[127:0];
                    end
                end
                3'd3: begin
                    // 131 bits hold eight 128-bit values without overflow.
                    acc_d = last_dat ? '0 : run_sum;
                    if (last_dat) begin
                        valid_d = 1'b1;
                        out_d   = run_sum[130:3];
                    end
                end
                3'd4: begin
                    if ((datum > F4_LOW) && (datum < F4_HIGH)) begin
                        valid_d = 1'b1;
                        out_d   = datum;
                    end
                end
                3'd5: begin
                    if ((datum < F5_LOW) || (datum > F5_HIGH)) begin
                        valid_d = 1'b1;
                        out_d   = datum;
                    end
                end
                3'd6: begin
                    acc_d = last_dat ? '0 : run_max;
                    if (last_dat && (first_q || (run_max[127:0] > peak_q))) begin
                        valid_d = 1'b1;
                        out_d   = run_max[127:0];
                        peak_d  = run_max[127:0];
                        first_d = 1'b0;
                    end
                end
                3'd7: begin
                    acc_d = last_dat ? '0 : run_min;
                    if (last_dat && (first_q || (run_min[127:0] < peak_q))) begin
                        valid_d = 1'b1;
                        out_d   = run_min[127:0];
                        peak_d  = run_min[127:0];
                        first_d = 1'b0;
                    end
                end
                default: begin
                    acc_d = acc_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q    <= '0;
            byte_cnt_q <= '0;
            dat_cnt_q  <= '0;
            acc_q      <= '0;
            peak_q     <= '0;
            first_q    <= 1'b1;
            valid_q    <= 1'b0;
            out_q      <= '0;
        end else begin
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            dat_cnt_q  <= dat_cnt_d;
            acc_q      <= acc_d;
            peak_q     <= peak_d;
            first_q    <= first_d;
            valid_q    <= valid_d;
            out_q      <= out_d;
        end
    end

    assign busy    = 1'b0;
    assign valid   = valid_q;
    assign iot_out = out_q;

endmodule

// File: tb/tb_iot_data_filter.sv
module tb_iot_data_filter;

    logic         clk;
    logic         rst;
    logic         in_en;
    logic [7:0]   iot_in;
    logic [2:0]   fn_sel;
    logic         busy;
    logic         valid;
    logic [127:0] iot_out;

    int n_tests;
    int n_fail;

    logic [127:0] got_q[$];

    localparam logic [127:0] ALL1 = {128{1'b1}};

    iot_data_filter dut (
        .clk    (clk),
        .rst    (rst),
        .in_en  (in_en),
        .iot_in (iot_in),
        .fn_sel (fn_sel),
        .busy   (busy),
        .valid  (valid),
        .iot_out(iot_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every result strobe, sampled away from the rising edge.
    always @(negedge clk) begin
        if (valid === 1'b1) got_q.push_back(iot_out);
    end

    function automatic logic [127:0] peek(input int idx);
        if (idx < got_q.size()) return got_q[idx];
        return 'x;
    endfunction

    task automatic idle(input int n);
        in_en = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_en  = 1'b1;
        iot_in = b;
        @(posedge clk);
        #1;
        in_en  = 1'b0;
    endtask

    task automatic send_datum(input logic [127:0] d, input bit gap);
        for (int i = 0; i < 16; i++) begin
            send_byte(d[127-8*i -: 8]);
            if (gap && (i % 3 == 1)) idle(2);
        end
    endtask

    task automatic do_reset(input logic [2:0] f);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        in_en  = 1'b0;
        fn_sel = f;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        got_q.delete();
    endtask

    task automatic test_reset;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", valid); end
        n_tests++;
        if (iot_out !== 128'd0) begin n_fail++; $display("FAIL reset_iot_out got %h exp 0", iot_out); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        do_reset(3'd1);
    endtask

    task automatic test_max;
        logic [127:0] d[8] = '{128'd1, 128'd9, 128'd3, 128'd0, 128'd4, 128'd5, 128'd6, 128'd2};
        do_reset(3'd1);
        for (int i = 0; i < 7; i++) send_datum(d[i], 1'b0);
        idle(3);
        n_tests++;
        if (got_q.size() != 0) begin n_fail++; $display("FAIL max_early got %0d valids exp 0", got_q.size()); end
        send_datum(d[7], 1'b0);
        idle(3);
        n_tests++;
        if (got_q.size() != 1) begin n_fail++; $display("FAIL max_count got %0d exp 1", got_q.size()); end
        n_tests++;
        if (peek(0) !== 128'd9) begin n_fail++; $display("FAIL max_value got %h exp 9", peek(0)); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_low got %b exp 0", busy); end
    endtask

    task automatic test_min;
        logic [127:0] d[8] = '{128'd1, 128'd9, 128'd3, 128'd0, 128'd4, 128'd5, 128'd6, 128'd2};
        do_reset(3'd2);
        for (int i = 0; i < 8; i++) send_datum(d[i], 1'b0);
        idle(3);
        n_tests++;
        if (got_q.size() != 1) begin n_fail++; $display("FAIL min_count got %0d exp 1", got_q.size()); end
        n_tests++;
        if (peek(0) !== 128'd0) begin n_fail++; $display("FAIL min_value got %h exp 0", peek(0)); end
    endtask

    task automatic test_avg;
        do_reset(3'd3);
        for (int i = 1; i <= 8; i++) send_datum(128'(i), 1'b0);
        for (int i = 0; i < 8; i++) send_datum(ALL1, 1'b0);
        idle(3);
        n_tests++;
        if (got_q.size() != 2) begin n_fail++; $display("FAIL avg_count got %0d exp 2", got_q.size()); end
        n_tests++;
        if (peek(0) !== 128'd4) begin n_fail++; $display("FAIL avg_small got %h exp 4", peek(0)); end
        n_tests++;
        if (peek(1) !== ALL1) begin n_fail++; $display("FAIL avg_ones got %h exp %h", peek(1), ALL1); end
    endtask

    task automatic test_extract;
        do_reset(3'd4);
        send_datum(128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0);
        send_datum(128'h6FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b0);
        send_datum(128'hAFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b0);
        send_datum(128'h7000_0000_0000_0000_0000_0000_0000_0000, 1'b0);
        idle(3);
        n_tests++;
        if (got_q.size() != 2) begin n_fail++; $display("FAIL extract_count got %0d exp 2", got_q.size()); end
        n_tests++;
        if (peek(0) !== 128'h8000_0000_0000_0000_0000_0000_0000_0000) begin
            n_fail++; $display("FAIL extract_first got %h exp 8000..0", peek(0));
        end
        n_tests++;
        if (peek(1) !== 128'h7000_0000_0000_0000_0000_0000_0000_0000) begin
            n_fail++; $display("FAIL extract_second got %h exp 7000..0", peek(1));
        end
    endtask

    task automatic test_exclude;
        do_reset(3'd5);
        send_datum(128'h1, 1'b0);
        send_datum(128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b0);
        send_datum(128'hC000_0000_0000_0000_0000_0000_0000_0000, 1'b0);
        send_datum(128'h9000_0000_0000_0000_0000_0000_0000_0000, 1'b0);
        idle(3);
        n_tests++;
        if (got_q.size() != 2) begin n_fail++; $display("FAIL exclude_count got %0d exp 2", got_q.size()); end
        n_tests++;
        if (peek(0) !== 128'h1) begin n_fail++; $display("FAIL exclude_first got %h exp 1", peek(0)); end
        n_tests++;
        if (peek(1) !== 128'hC000_0000_0000_0000_0000_0000_0000_0000) begin
            n_fail++; $display("FAIL exclude_second got %h exp c000..0", peek(1));
        end
    endtask

    // Each round is seven filler values plus the extreme m in slot 3.
    task automatic send_round(input logic [127:0] filler, input logic [127:0] m);
        for (int i = 0; i < 8; i++) send_datum((i == 3) ? m : filler, 1'b0);
    endtask

    task automatic test_peak_max;
        do_reset(3'd6);
        send_round(128'd1, 128'd5);
        send_round(128'd1, 128'd3);
        send_round(128'd1, 128'd7);
        send_round(128'd1, 128'd7);
        idle(3);
        n_tests++;
        if (got_q.size() != 2) begin n_fail++; $display("FAIL peakmax_count got %0d exp 2", got_q.size()); end
        n_tests++;
        if (peek(0) !== 128'd5) begin n_fail++; $display("FAIL peakmax_first got %h exp 5", peek(0)); end
        n_tests++;
        if (peek(1) !== 128'd7) begin n_fail++; $display("FAIL peakmax_second got %h exp 7", peek(1)); end
    endtask

    task automatic test_peak_min;
        do_reset(3'd7);
        send_round(128'd100, 128'd5);
        send_round(128'd100, 128'd6);
        send_round(128'd100, 128'd2);
        send_round(128'd100, 128'd2);
        idle(3);
        n_tests++;
        if (got_q.size() != 2) begin n_fail++; $display("FAIL peakmin_count got %0d exp 2", got_q.size()); end
        n_tests++;
        if (peek(0) !== 128'd5) begin n_fail++; $display("FAIL peakmin_first got %h exp 5", peek(0)); end
        n_tests++;
        if (peek(1) !== 128'd2) begin n_fail++; $display("FAIL peakmin_second got %h exp 2", peek(1)); end
    endtask

    task automatic test_stall;
        logic [127:0] d[8] = '{128'd1, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 128'd3, 128'd0,
                               128'd4, 128'd5, 128'd6, 128'd2};
        do_reset(3'd1);
        for (int i = 0; i < 8; i++) send_datum(d[i], 1'b1);
        idle(3);
        n_tests++;
        if (got_q.size() != 1) begin n_fail++; $display("FAIL stall_count got %0d exp 1", got_q.size()); end
        n_tests++;
        if (peek(0) !== 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677) begin
            n_fail++; $display("FAIL stall_value got %h exp 0123..6677", peek(0));
        end
    endtask

    task automatic test_reset_mid;
        logic [127:0] big;
        big = 128'h500;
        do_reset(3'd1);
        for (int i = 0; i < 3; i++) send_datum(big, 1'b0);
        for (int i = 0; i < 10; i++) send_byte(8'hFF);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b exp 0", valid); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);
        n_tests++;
        if (got_q.size() != 0) begin n_fail++; $display("FAIL midrst_quiet got %0d valids exp 0", got_q.size()); end
        for (int i = 1; i <= 7; i++) send_datum(128'(i), 1'b0);
        send_datum(128'h20, 1'b0);
        idle(3);
        n_tests++;
        if (got_q.size() != 1) begin n_fail++; $display("FAIL midrst_count got %0d exp 1", got_q.size()); end
        n_tests++;
        if (peek(0) !== 128'h20) begin n_fail++; $display("FAIL midrst_value got %h exp 20", peek(0)); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        in_en   = 1'b0;
        iot_in  = 8'h00;
        fn_sel  = 3'd0;
        test_reset();
        test_max();
        test_min();
        test_avg();
        test_extract();
        test_exclude();
        test_peak_max();
        test_peak_min();
        test_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
